// File: rtl/mseq_if.sv
// mseq_if: receive-side bit interface between an m-sequence sink and its consumer.
interface mseq_if #(parameter int WIDTH = 5);
  logic [WIDTH-1:0] type_f;
  logic             bit_in;
  logic             bit_valid;
  logic             out_valid;
  logic             corr_bit;
  logic             bit_err;
  logic             locked;
  logic [15:0]      err_total;
  modport master (output type_f, bit_in, bit_valid,
                  input  out_valid, corr_bit, bit_err, locked, err_total);
  modport slave  (input  type_f, bit_in, bit_valid,
                  output out_valid, corr_bit, bit_err, locked, err_total);
endinterface

// File: rtl/mseq_sync.sv
// mseq_sync: acquires lock on an mfun m-sequence, flywheels it and counts bit errors.
module mseq_sync #(
  parameter int WIDTH    = 5,
  parameter int LOCK_CNT = 31,
  parameter int WINDOW   = 32,
  parameter int ERR_MAX  = 3
) (
  input logic   clk,
  input logic   rst_n,
  mseq_if.slave bus
);
  localparam int FW = $clog2(WIDTH + 1);
  localparam int MW = $clog2(LOCK_CNT + 1);
  localparam int WW = $clog2(WINDOW) > 0 ? $clog2(WINDOW) : 1;
  localparam int EW = $clog2(ERR_MAX + 1);
  localparam logic [FW-1:0] F_LAST = FW'(WIDTH - 1);
  localparam logic [MW-1:0] M_LAST = MW'(LOCK_CNT - 1);
  localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
  localparam logic [EW-1:0] E_MAX  = EW'(ERR_MAX);
  typedef enum logic [1:0] {FILL, HUNT, LOCK} state_t;
  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [FW-1:0]    fill_cnt;
  logic [MW-1:0]    match_cnt;
  logic [WW-1:0]    win_cnt;
  logic [EW-1:0]    err_win;
  logic             pred, mis, hunt_err, drop;
  logic [WIDTH-1:0] shift_in;
  logic [EW-1:0]    lock_ew;
  always_comb begin
    pred     = ^(sr & bus.type_f);
    mis      = bus.bit_in != pred;
    hunt_err = mis || sr == '0;
    shift_in = {sr[WIDTH-2:0], bus.bit_in};
    lock_ew  = err_win + EW'(mis);
    drop     = lock_ew == E_MAX;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FILL;
      sr            <= '0;
      fill_cnt      <= '0;
      match_cnt     <= '0;
      win_cnt       <= '0;
      err_win       <= '0;
      bus.out_valid <= 1'b0;
      bus.corr_bit  <= 1'b0;
      bus.bit_err   <= 1'b0;
      bus.locked    <= 1'b0;
      bus.err_total <= '0;
    end else begin
      bus.out_valid <= bus.bit_valid;
      bus.bit_err   <= 1'b0;
      if (bus.bit_valid) begin
        case (state)
          FILL: begin
            sr           <= shift_in;
            fill_cnt     <= fill_cnt + FW'(1);
            bus.corr_bit <= bus.bit_in;
            if (fill_cnt == F_LAST) state <= HUNT;
          end
          HUNT: begin
            sr           <= shift_in;
            bus.corr_bit <= bus.bit_in;
            bus.bit_err  <= hunt_err;
            if (hunt_err) match_cnt <= '0;
            else if (match_cnt == M_LAST) begin
              match_cnt  <= '0;
              win_cnt    <= '0;
              err_win    <= '0;
              state      <= LOCK;
              bus.locked <= 1'b1;
            end else match_cnt <= match_cnt + MW'(1);
          end
          LOCK: begin
            bus.corr_bit <= pred;
            bus.bit_err  <= mis;
            win_cnt      <= win_cnt == W_LAST ? '0 : win_cnt + WW'(1);
            if (mis && ~&bus.err_total) bus.err_total <= bus.err_total + 16'd1;
            // On loss of lock, re-seed from the received stream rather than the flywheel
            if (drop) begin
              state      <= HUNT;
              bus.locked <= 1'b0;
              match_cnt  <= '0;
              sr         <= shift_in;
            end else begin
              sr      <= {sr[WIDTH-2:0], pred};
              err_win <= win_cnt == W_LAST ? '0 : lock_ew;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mseq_sync.sv
// tb_mseq_sync: randomized and directed checks of mseq_sync against a behavioural model.
module tb_mseq_sync;
  localparam int WIDTH = 5, LOCK_CNT = 31, WINDOW = 32, ERR_MAX = 3;
  localparam logic [4:0] TF = 5'b11101;
  logic clk = 1'b0, rst_n = 1'b0;
  mseq_if #(.WIDTH(WIDTH)) bus();
  mseq_sync #(.WIDTH(WIDTH), .LOCK_CNT(LOCK_CNT), .WINDOW(WINDOW), .ERR_MAX(ERR_MAX))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int n_chk = 0, n_pass = 0;
  int vcnt, ocnt, ecnt, lock_at, lk_seen;
  logic [4:0] fase;
  bit orig;
  // behavioural model state
  int mode, n_fill, n_match, n_win, n_err, tot;
  int hist[$];
  bit exp_ov, exp_corr, exp_be, exp_lk;
  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
  endtask
  task automatic model_reset();
    mode = 0; n_fill = 0; n_match = 0; n_win = 0; n_err = 0; tot = 0;
    hist.delete();
    exp_ov = 0; exp_corr = 0; exp_be = 0; exp_lk = 0;
  endtask
  task automatic push(input bit b);
    hist.push_back(int'(b));
    if (hist.size() > WIDTH) void'(hist.pop_front());
  endtask
  task automatic model_step(input bit b, input bit v);
    bit p, e;
    int nz;
    exp_ov = v; exp_be = 0;
    if (!v) return;
    p = 0; nz = 0;
    for (int k = 0; k < hist.size() && k < WIDTH; k++) begin
      if (TF[k]) p ^= hist[hist.size()-1-k][0];
      nz += hist[hist.size()-1-k];
    end
    if (mode == 0) begin
      exp_corr = b; push(b); n_fill++;
      if (n_fill == WIDTH) mode = 1;
    end else if (mode == 1) begin
      e = (b != p) || nz == 0;
      exp_corr = b; exp_be = e; push(b);
      if (e) n_match = 0;
      else if (++n_match == LOCK_CNT) begin
        mode = 2; n_match = 0; n_win = 0; n_err = 0; exp_lk = 1;
      end
    end else begin
      e = b != p;
      exp_corr = p; exp_be = e;
      if (e && tot < 65535) tot++;
      n_win++;
      if (n_err + int'(e) == ERR_MAX) begin
        mode = 1; n_match = 0; exp_lk = 0; push(b);
      end else begin
        push(p); n_err += int'(e);
        if (n_win == WINDOW) n_err = 0;
      end
      if (n_win == WINDOW) n_win = 0;
    end
  endtask
  always @(posedge clk) begin
    #1;
    check("out_valid", int'(bus.out_valid), int'(exp_ov));
    check("locked", int'(bus.locked), int'(exp_lk));
    check("err_total", int'(bus.err_total), tot);
    if (exp_ov) begin
      check("corr_bit", int'(bus.corr_bit), int'(exp_corr));
      check("bit_err", int'(bus.bit_err), int'(exp_be));
    end
  end
  task automatic send(input bit b, input bit v);
    @(negedge clk);
    bus.bit_in = b; bus.bit_valid = v;
    model_step(b, v);
    if (v) vcnt++;
    @(posedge clk); #2;
    if (bus.out_valid) ocnt++;
    if (bus.bit_err) ecnt++;
    if (lk_seen == 0 && bus.locked) begin lk_seen = 1; lock_at = vcnt; end
  endtask
  task automatic tx(input bit inv, input bit v);
    bit b;
    if (v) begin
      b = ^(fase & TF); fase = {fase[3:0], b}; orig = b;
      send(b ^ inv, 1'b1);
    end else send(1'($urandom), 1'b0);
  endtask
  task automatic do_reset(input bit chk);
    @(negedge clk);
    bus.bit_valid = 0; rst_n = 0;
    model_reset();
    #1;
    if (chk) begin
      check("rst_out_valid", int'(bus.out_valid), 0);
      check("rst_corr_bit", int'(bus.corr_bit), 0);
      check("rst_bit_err", int'(bus.bit_err), 0);
      check("rst_locked", int'(bus.locked), 0);
      check("rst_err_total", int'(bus.err_total), 0);
    end
    @(negedge clk);
    rst_n = 1; vcnt = 0; ocnt = 0; ecnt = 0; lk_seen = 0; lock_at = 0;
  endtask
  initial begin
    bus.type_f = TF; bus.bit_in = 0; bus.bit_valid = 0;
    model_reset();
    repeat (2) @(negedge clk);
    do_reset(1'b1);
    fase = 5'b10101;
    for (int i = 1; i <= 100; i++) tx(1'b0, 1'b1);
    check("clean_lock_at", lock_at, WIDTH + LOCK_CNT);
    check("clean_err_total", int'(bus.err_total), 0);
    check("clean_err_pulses", ecnt, 0);
    do_reset(1'b0);
    fase = 5'b10101;
    for (int i = 1; i <= 60; i++) begin
      tx(i == 50, 1'b1);
      if (i == 50) begin
        check("single_bit_err", int'(bus.bit_err), 1);
        check("single_corr_orig", int'(bus.corr_bit), int'(orig));
      end
    end
    check("single_locked", int'(bus.locked), 1);
    check("single_err_total", int'(bus.err_total), 1);
    do_reset(1'b0);
    for (int i = 1; i <= 55; i++) tx(i == 45 || i == 50 || i == 55, 1'b1);
    check("drop_locked", int'(bus.locked), 0);
    check("drop_err_total", int'(bus.err_total), 3);
    for (int i = 0; i < 80; i++) tx(1'b0, 1'b1);
    check("relock", int'(bus.locked), 1);
    do_reset(1'b0);
    for (int i = 1; i <= 100; i++) tx(i == 40 || i == 60 || i == 75 || i == 90, 1'b1);
    check("window_locked", int'(bus.locked), 1);
    check("window_err_total", int'(bus.err_total), 4);
    do_reset(1'b0);
    for (int i = 0; i < 200; i++) send(1'b0, 1'b1);
    check("zero_never_lock", lk_seen, 0);
    check("zero_err_pulses", ecnt, 200 - WIDTH);
    do_reset(1'b0);
    while (vcnt < 80) tx(1'b0, 1'($urandom_range(0, 1)));
    check("gap_lock_at", lock_at, WIDTH + LOCK_CNT);
    check("gap_ov_count", ocnt, vcnt);
    tx(1'b1, 1'b1);
    check("gap_err_total", int'(bus.err_total), 1);
    do_reset(1'b1);
    while (vcnt < 45) tx(1'b0, 1'($urandom_range(0, 3) != 0));
    check("rst_relock_at", lock_at, WIDTH + LOCK_CNT);
    do_reset(1'b0);
    for (int i = 0; i < 1500; i++) tx($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0);
    @(negedge clk);
    bus.bit_valid = 0;
    model_step(1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #3;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mseq_sync.md
Name: mseq_sync

Overview:
- Receive-side counterpart of the mfun m-sequence generator.
- Takes a serial bitstream produced by mfun (same type_f polynomial) and acquires lock on it.
- After lock, flywheels a local generator to predict and correct bits, reports bit errors, and drops lock when errors become excessive.
- Sits at the sink of a link whose source is mfun; used for bit-error measurement.

Parameters:
- WIDTH, 5, LFSR length. Equals mfun register width.
- LOCK_CNT, 31, consecutive correct predictions in HUNT needed to declare lock.
- WINDOW, 32, number of valid bits per error-counting window in LOCK.
- ERR_MAX, 3, errors within one window that force loss of lock.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- type_f  in  WIDTH  feedback polynomial mask. Quasi-static; change only in reset.
- bit_in  in  1  received sequence bit.
- bit_valid  in  1  bit_in qualifier. One bit per asserted cycle; gaps allowed.
- out_valid  out  1  registered; pulses 1 cycle after each accepted bit_valid.
- corr_bit  out  1  corrected bit. Predicted bit in LOCK, otherwise bit_in.
- bit_err  out  1  pulse with out_valid when prediction != bit_in. Only in HUNT or LOCK.
- locked  out  1  high while FSM is in LOCK.
- err_total  out  16  saturating count of bit_err pulses while in LOCK.

Behaviour:
- Sequence convention (matches mfun):
  - sum = ^(fase & type_f)
  - fase_new = {fase[WIDTH-2:0], sum}
  - Each transmitted bit is therefore the parity of the previous WIDTH bits masked by type_f.
- Internal shift register sr[WIDTH-1:0], fill counter, match counter, window counter win_cnt, window error counter err_win.
- Prediction: pred = ^(sr & type_f).
- Reset (async, rst_n=0):
  - sr=0, all counters 0, FSM=FILL.
  - Outputs: out_valid=0, corr_bit=0, bit_err=0, locked=0, err_total=0.
  - Reset mid-operation discards all state; the next bit after release starts a fresh FILL.
- When bit_valid=0, all state and counters hold and out_valid=0. Gaps never affect lock.
- All outputs are registered. Latency bit_valid -> out_valid/corr_bit/bit_err is 1 clock.
- FSM, evaluated only on cycles with bit_valid=1:
  - FILL:
    - sr <= {sr[WIDTH-2:0], bit_in}; fill count +1; bit_err=0.
    - After WIDTH bits, go to HUNT.
  - HUNT:
    - A mismatch (bit_in != pred) or sr==0 is an error: bit_err=1 (sr==0 case included), match count cleared.
    - Otherwise match count +1.
    - sr always shifts in bit_in.
    - When match count reaches LOCK_CNT, go to LOCK with win_cnt=0, err_win=0.
    - An all-zero stream never locks.
  - LOCK:
    - sr shifts in pred (flywheel), so received errors do not propagate into sr.
    - corr_bit=pred; bit_err=(bit_in != pred).
    - win_cnt increments and wraps WINDOW-1 -> 0. err_win counts errors.
    - If err_win+error reaches ERR_MAX, go to HUNT on that same edge:
      - clear match count;
      - load sr <= {sr[WIDTH-2:0], bit_in} to re-acquire from received data.
    - Otherwise, at wrap, err_win <= 0. The error on the wrap bit is counted toward the check before clearing.
- err_total increments on every LOCK error and saturates at 16'hFFFF. Errors in HUNT are not added. Cleared only by reset.
- locked is updated on the same edge as the state change, visible 1 cycle after the deciding bit.
- Lock time from reset with clean input and continuous bit_valid:
  - locked=1 after WIDTH+LOCK_CNT = 36 valid bits;
  - visible on the clock following the 36th bit.

Test Plan:
- Clean lock: mfun seed 5'b10101, type_f 5'b11101, 100 continuous bits.
  - -> locked rises after bit 36; bit_err=0 throughout; err_total=0; corr_bit equals the generator sum for every bit.
- Single error in LOCK: invert bit 50.
  - -> one bit_err pulse aligned with bit 50's out_valid; corr_bit is correct (original value); locked stays 1; err_total=1.
- Loss of lock: in LOCK, invert 3 bits within one 32-bit window.
  - -> locked drops on the 3rd error; err_total=3; re-lock occurs 31 clean bits later.
- Window clearing: 2 errors in one window, 2 in the next.
  - -> locked stays 1; err_total=4.
- Degenerate and gapped input, with reset:
  - all-zero bitstream for 200 bits -> locked never asserts; bit_err=1 on every HUNT bit.
  - clean stream with bit_valid toggling 1/0 -> lock after 36 valid bits; out_valid count equals bit_valid count.
  - rst_n low for 1 cycle mid-LOCK -> all outputs 0 immediately; re-lock after 36 further valid bits.
